conv_coef_loader: RTL and testbench
===================================

CONV_COEF_LOADER -- requirements
Module: conv_coef_loader

Interface
REQ-001 Parameter CONV_CORE_DEPTH, default 256, number of coefficients to load; legal range 2..4096.
REQ-002 Parameter APB_BASE_ADDR, default 0, APB address of coefficient 0 in the convolution core.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum ACCESS-phase wait for p_rdy before error.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle load request; honoured only in IDLE, RUN or ERROR.
REQ-007 stop  input  1  level request to leave RUN, or to end a load after the current transfer.
REQ-008 coef_addr  output  $clog2(CONV_CORE_DEPTH)  coefficient memory read address.
REQ-009 coef_rd  output  1  coefficient memory read strobe; data returns exactly 1 cycle later.
REQ-010 coef_data  input  32  coefficient memory read data.
REQ-011 p_sel, p_ce, p_we  output  1 each  APB master select, enable and write.
REQ-012 p_addr, p_wdata  output  32 each  APB address and write data.
REQ-013 p_strb  output  4  byte strobes; constant 4'b1111.
REQ-014 p_rdy  input  1  APB slave ready.
REQ-015 data_enable  output  1  drives the convolution core's data_enable.
REQ-016 busy, done, error  output  1 each  loading / one-cycle load-complete pulse / sticky timeout flag.

Function
REQ-017 States SHALL be IDLE, FETCH, SETUP, ACCESS, RUN, ERROR; index register idx counts 0..CONV_CORE_DEPTH-1.
REQ-018 In IDLE, RUN or ERROR, start SHALL clear idx and error, drop data_enable and enter FETCH on the next cycle.
REQ-019 FETCH SHALL drive coef_rd=1 and coef_addr=idx for one cycle, then go to SETUP.
REQ-020 On entry to SETUP, coef_data SHALL be latched into p_wdata; SETUP drives p_sel=1, p_ce=0, p_we=1, p_addr=APB_BASE_ADDR+idx for exactly one cycle.
REQ-021 ACCESS SHALL drive p_sel=1, p_ce=1, and hold p_addr/p_wdata stable until p_rdy=1 is sampled.
REQ-022 When p_rdy=1 in ACCESS: if idx=CONV_CORE_DEPTH-1, go to RUN; else if stop=1, go to IDLE; otherwise increment idx and go to FETCH.
REQ-023 Zero-wait-state load SHALL take exactly 3*CONV_CORE_DEPTH cycles from the first FETCH cycle to the first RUN cycle.
REQ-024 In RUN, data_enable SHALL be 1; done SHALL pulse for the first RUN cycle only.
REQ-025 stop=1 in RUN SHALL return to IDLE with data_enable=0 on the next cycle; start has priority when start and stop are both 1.
REQ-026 stop SHALL never abort an APB transfer: p_sel/p_ce are only released after the p_rdy handshake completes.
REQ-027 A wait counter SHALL clear on entering ACCESS; if it reaches TIMEOUT_CYCLES without p_rdy, go to ERROR with p_sel=p_ce=0 and error=1.
REQ-028 start in FETCH, SETUP or ACCESS SHALL be ignored.
REQ-029 busy SHALL be 1 exactly in FETCH, SETUP and ACCESS.
REQ-030 Outside SETUP and ACCESS, p_sel, p_ce and p_we SHALL be 0; p_addr and p_wdata hold their last values.

Reset
REQ-031 rst SHALL force IDLE, including mid-transfer, and set idx=0, wait counter=0, p_sel=p_ce=p_we=0, p_addr=p_wdata=0, coef_rd=0, coef_addr=0, data_enable=0, busy=0, done=0, error=0.

Structure
REQ-032 A shared package conv_ctrl_pkg SHALL hold the state enum, the 4'b1111 strobe constant and the APB width constants (32/32).
REQ-033 Single module, with no sub-module; the APB master phase logic stays inline in the FSM.

Verification (CONV_CORE_DEPTH=4, APB_BASE_ADDR=0x100, TIMEOUT_CYCLES=8, memory = 0x11,0x22,0x33,0x44)
REQ-034 Zero-wait slave, pulse start -> writes (0x100,0x11), (0x101,0x22), (0x102,0x33), (0x103,0x44); RUN after 12 cycles; done high for 1 cycle; data_enable=1.
REQ-035 Slave inserts 3 wait states on idx=2 -> p_addr=0x102 and p_wdata=0x33 stable for all 4 ACCESS cycles; total load time 15 cycles.
REQ-036 p_rdy held 0 on idx=1 -> ERROR after 8 ACCESS cycles; error=1, p_sel=0, data_enable=0; a later start reloads from idx 0 and clears error.
REQ-037 stop asserted in ACCESS of idx=1 -> that write completes, then IDLE with no write to 0x102 and done=0; stop in RUN -> data_enable=0 the next cycle.
REQ-038 rst pulsed during ACCESS of idx=2 -> all outputs at reset values the next cycle; start pulsed during the load -> load unaffected.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution-core control blocks:
// FSM state encoding and APB bus widths/strobe.
package conv_ctrl_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

  // Coefficients are always full-word writes
  localparam logic [APB_STRB_W-1:0] APB_STRB_ALL = APB_STRB_W'(4'b1111);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERROR  = 3'd5
  } conv_state_e;

endpackage

// File: rtl/conv_coef_loader_if.sv
// APB write-master bus between the coefficient loader and the convolution core.
interface conv_coef_loader_if;
  import conv_ctrl_pkg::*;

  logic                  p_sel;
  logic                  p_ce;
  logic                  p_we;
  logic [APB_ADDR_W-1:0] p_addr;
  logic [APB_DATA_W-1:0] p_wdata;
  logic [APB_STRB_W-1:0] p_strb;
  logic                  p_rdy;

  modport master (
    output p_sel, p_ce, p_we, p_addr, p_wdata, p_strb,
    input  p_rdy
  );

  modport slave (
    input  p_sel, p_ce, p_we, p_addr, p_wdata, p_strb,
    output p_rdy
  );

endinterface

// File: rtl/conv_coef_loader.sv
// Copies CONV_CORE_DEPTH coefficients from a local memory into the convolution
// core over APB, then enables the core; bounded wait on each APB access.
module conv_coef_loader
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned           CONV_CORE_DEPTH = 256,
  parameter logic [APB_ADDR_W-1:0] APB_BASE_ADDR   = '0,
  parameter int unsigned           TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stop,
  output logic [$clog2(CONV_CORE_DEPTH)-1:0] coef_addr,
  output logic                               coef_rd,
  input  logic [APB_DATA_W-1:0]              coef_data,
  conv_coef_loader_if.master                 apb,
  output logic                               data_enable,
  output logic                               busy,
  output logic                               done,
  output logic                               error
);

  localparam int unsigned IDX_W  = $clog2(CONV_CORE_DEPTH);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CONV_CORE_DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  conv_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [IDX_W-1:0]      coef_addr_q, coef_addr_d;
  logic                  coef_rd_q, coef_rd_d;
  logic                  p_sel_q, p_sel_d;
  logic                  p_ce_q, p_ce_d;
  logic                  p_we_q, p_we_d;
  logic [APB_ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [APB_DATA_W-1:0] p_wdata_q, p_wdata_d;
  logic                  data_enable_q, data_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  // State, index, timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wait_q        <= '0;
      coef_addr_q   <= '0;
      coef_rd_q     <= 1'b0;
      p_sel_q       <= 1'b0;
      p_ce_q        <= 1'b0;
      p_we_q        <= 1'b0;
      p_addr_q      <= '0;
      p_wdata_q     <= '0;
      data_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      coef_addr_q   <= coef_addr_d;
      coef_rd_q     <= coef_rd_d;
      p_sel_q       <= p_sel_d;
      p_ce_q        <= p_ce_d;
      p_we_q        <= p_we_d;
      p_addr_q      <= p_addr_d;
      p_wdata_q     <= p_wdata_d;
      data_enable_q <= data_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state they describe.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    coef_addr_d   = coef_addr_q;
    p_addr_d      = p_addr_q;
    p_wdata_d     = p_wdata_q;
    error_d       = error_q;
    coef_rd_d     = 1'b0;
    p_sel_d       = 1'b0;
    p_ce_d        = 1'b0;
    p_we_d        = 1'b0;
    data_enable_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          idx_d   = '0;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end else if (stop && (state_q == ST_RUN)) begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Memory answers the FETCH strobe by the end of the cycle
        p_wdata_d = coef_data;
        p_addr_d  = APB_BASE_ADDR + APB_ADDR_W'(idx_q);
        state_d   = ST_SETUP;
      end
      ST_SETUP: begin
        wait_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.p_rdy) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else if (stop) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_FETCH) begin
      coef_addr_d = idx_d;
    end

    coef_rd_d     = (state_d == ST_FETCH);
    p_sel_d       = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    p_ce_d        = (state_d == ST_ACCESS);
    p_we_d        = p_sel_d;
    busy_d        = (state_d == ST_FETCH) || p_sel_d;
    data_enable_d = (state_d == ST_RUN);
    done_d        = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  assign coef_addr   = coef_addr_q;
  assign coef_rd     = coef_rd_q;
  assign apb.p_sel   = p_sel_q;
  assign apb.p_ce    = p_ce_q;
  assign apb.p_we    = p_we_q;
  assign apb.p_addr  = p_addr_q;
  assign apb.p_wdata = p_wdata_q;
  assign apb.p_strb  = APB_STRB_ALL;
  assign data_enable = data_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_conv_coef_loader.sv
// Scoreboard bench for conv_coef_loader: directed load scenarios followed by
// randomized loads with random wait states, stops, timeouts and resets.
module tb_conv_coef_loader;
  import conv_ctrl_pkg::*;

  localparam int unsigned D    = 4;
  localparam logic [31:0] BASE = 32'h100;
  localparam int unsigned TO   = 8;
  localparam int K_RUN  = 0;
  localparam int K_IDLE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  coef_addr;
  logic        coef_rd;
  logic [31:0] coef_data;
  logic        data_enable, busy, done, error;

  conv_coef_loader_if bus ();

  conv_coef_loader #(
    .CONV_CORE_DEPTH (D),
    .APB_BASE_ADDR   (BASE),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .coef_addr   (coef_addr),
    .coef_rd     (coef_rd),
    .coef_data   (coef_data),
    .apb         (bus),
    .data_enable (data_enable),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int kind;
    int cycles;
  } out_t;

  logic [31:0] mem [D];
  int          plan [D];
  wr_t         wr_q [$];
  out_t        out_q [$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Memory model: data is only meaningful while the read strobe is up
  assign coef_data = coef_rd ? mem[coef_addr] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: expected writes and how/when the load ends
  task automatic predict(input int stop_idx, input int reset_idx);
    out_t o;
    wr_t  w;
    o.kind   = K_RUN;
    o.cycles = 0;
    for (int i = 0; i < int'(D); i++) begin
      if (reset_idx >= 0 && i == reset_idx) return;
      if (plan[i] >= int'(TO)) begin
        o.cycles += 2 + int'(TO);
        o.kind = K_ERR;
        break;
      end
      w.addr = BASE + 32'(i);
      w.data = mem[i];
      wr_q.push_back(w);
      o.cycles += 3 + plan[i];
      if (i == int'(D) - 1) begin
        o.kind = K_RUN;
        break;
      end
      if (i == stop_idx) begin
        o.kind = K_IDLE;
        break;
      end
    end
    out_q.push_back(o);
  endtask

  // APB slave with per-index wait states, plus the output monitor
  int          acc_cnt = 0;
  int          sl_idx;
  int          cyc = 0;
  int          obs_kind;
  logic        prev_acc = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] acc_addr, acc_data;
  wr_t         exp_wr;
  out_t        exp_out;

  always @(negedge clk) begin
    if (rst) begin
      bus.p_rdy = 1'b0;
      acc_cnt   = 0;
      prev_acc  = 1'b0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
      cyc       = 0;
    end else begin
      if (bus.p_sel && bus.p_ce) begin
        sl_idx = int'(bus.p_addr - BASE);
        bus.p_rdy = (sl_idx >= 0 && sl_idx < int'(D)) ? (acc_cnt >= plan[sl_idx]) : 1'b1;
        acc_cnt++;
        if (!prev_acc) begin
          acc_addr = bus.p_addr;
          acc_data = bus.p_wdata;
        end else begin
          chk("access_addr_stable", bus.p_addr, acc_addr);
          chk("access_wdata_stable", bus.p_wdata, acc_data);
        end
        chk("p_we_in_access", 32'(bus.p_we), 32'd1);
        if (bus.p_rdy) begin
          if (wr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", bus.p_addr, bus.p_wdata);
          end else begin
            exp_wr = wr_q.pop_front();
            chk("write_addr", bus.p_addr, exp_wr.addr);
            chk("write_data", bus.p_wdata, exp_wr.data);
            chk("write_strb", 32'(bus.p_strb), 32'hF);
          end
        end
        prev_acc = !bus.p_rdy;
      end else begin
        bus.p_rdy = 1'b0;
        acc_cnt   = 0;
        prev_acc  = 1'b0;
      end

      if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
      prev_done = done;
      if (!busy) chk("p_sel_when_not_loading", 32'(bus.p_sel), 32'd0);

      if (busy) begin
        if (!prev_busy) begin
          cyc = 1;
          chk("error_cleared_on_start", 32'(error), 32'd0);
          chk("data_enable_off_loading", 32'(data_enable), 32'd0);
        end else begin
          cyc++;
        end
      end else if (prev_busy) begin
        if (done && data_enable && !error) obs_kind = K_RUN;
        else if (error && !data_enable && !bus.p_sel && !bus.p_ce) obs_kind = K_ERR;
        else if (!done && !error && !data_enable) obs_kind = K_IDLE;
        else obs_kind = 99;
        if (out_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_load_end: got kind %0d after %0d cycles, required none", obs_kind, cyc);
        end else begin
          exp_out = out_q.pop_front();
          chk("load_outcome", 32'(obs_kind), 32'(exp_out.kind));
          chk("load_cycles", 32'(cyc), 32'(exp_out.cycles));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic check_reset_values();
    chk("rst_coef_addr", 32'(coef_addr), 32'd0);
    chk("rst_coef_rd", 32'(coef_rd), 32'd0);
    chk("rst_p_sel", 32'(bus.p_sel), 32'd0);
    chk("rst_p_ce", 32'(bus.p_ce), 32'd0);
    chk("rst_p_we", 32'(bus.p_we), 32'd0);
    chk("rst_p_addr", bus.p_addr, 32'd0);
    chk("rst_p_wdata", bus.p_wdata, 32'd0);
    chk("rst_data_enable", 32'(data_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  // Drives one load; returns at the first cycle after the load ends
  task automatic run_load(input int stop_idx, input int reset_idx);
    bit finished = 0;
    predict(stop_idx, reset_idx);
    start = 1'b1;
    for (int c = 0; c < 600 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) begin
        stop = 1'b0;
        finished = 1;
      end else if (reset_idx >= 0 && bus.p_sel && bus.p_ce && bus.p_addr == BASE + 32'(reset_idx)) begin
        rst  = 1'b1;
        stop = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        finished = 1;
      end else begin
        if (stop_idx >= 0 && bus.p_sel && bus.p_ce && bus.p_addr == BASE + 32'(stop_idx)) stop = 1'b1;
        if ($urandom_range(0, 5) == 0) start = 1'b1;
      end
    end
    if (!finished) begin
      n_checks++;
      $display("FAIL load_timeout: got busy=%0d after 600 cycles, required load end", busy);
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  task automatic stop_in_run();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_run_data_enable", 32'(data_enable), 32'd0);
    chk("stop_run_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_plan_zero();
    for (int i = 0; i < int'(D); i++) plan[i] = 0;
  endtask

  initial begin
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    set_plan_zero();
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait load, then stop from RUN
    run_load(-1, -1);
    @(negedge clk);
    chk("run_data_enable", 32'(data_enable), 32'd1);
    stop_in_run();
    @(negedge clk);

    // Three wait states on index 2
    plan[2] = 3;
    run_load(-1, -1);
    set_plan_zero();
    @(negedge clk);

    // Slave never ready on index 1: timeout, sticky error
    plan[1] = 100;
    run_load(-1, -1);
    repeat (3) @(negedge clk);
    chk("error_sticky", 32'(error), 32'd1);
    chk("error_p_sel", 32'(bus.p_sel), 32'd0);
    chk("error_data_enable", 32'(data_enable), 32'd0);
    set_plan_zero();

    // Reload from ERROR, ending with stop during index 1
    run_load(1, -1);
    @(negedge clk);

    // Reset during ACCESS of index 2
    plan[2] = 2;
    run_load(-1, 2);
    set_plan_zero();
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      int r;
      int stop_idx;
      int reset_idx;
      stop_idx  = -1;
      reset_idx = -1;
      for (int i = 0; i < int'(D); i++) begin
        mem[i]  = $urandom;
        plan[i] = $urandom_range(0, 3);
      end
      r = $urandom_range(0, 9);
      if (r == 0) plan[$urandom_range(0, D - 1)] = int'(TO) + $urandom_range(0, 3);
      else if (r <= 2) stop_idx = $urandom_range(0, D - 1);
      else if (r == 3) begin
        reset_idx = $urandom_range(0, D - 1);
        plan[reset_idx] = $urandom_range(1, 3);
      end
      run_load(stop_idx, reset_idx);
      if (data_enable && $urandom_range(0, 1) == 1) stop_in_run();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("outcome_queue_drained", 32'(out_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
